// File: rtl/mix_ctrl_pkg.sv
// Shared definitions for the mixer scheduler: the phase encoding seen on
// act_phase, default array/timing constants, and a small width helper.
package mix_ctrl_pkg;

    localparam int DEF_NUM_MIXERS   = 70;
    localparam int DEF_LOAD_CYCLES  = 8;
    localparam int DEF_FLUSH_CYCLES = 4;
    localparam int MIXER_W          = 7;

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_LOAD_A = 3'd1,
        PH_LOAD_B = 3'd2,
        PH_MIX    = 3'd3,
        PH_FLUSH  = 3'd4
    } phase_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mix_cmd_fifo.sv
// Synchronous command queue for the mixer scheduler.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   wr_en, wr_data    - push request/data (ignored when full)
//   rd_en, rd_data    - pop request; rd_data is the current head entry
//   count             - number of stored entries
//   full, empty       - derived from the registered count, so an entry
//                       written on an edge is only visible after that edge
module mix_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mix_scheduler.sv
// Mixer-array scheduler: queues mix commands and sequences each one through
// LOAD_A, LOAD_B, MIX and FLUSH valve phases, reporting completion.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   cmd_valid/cmd_ready           - command handshake
//   cmd_mixer, cmd_dur            - target mixer index and mix duration
//   abort                         - cut the active load/mix short into FLUSH
//   act_en, act_mixer, act_phase  - current actuation
//   done_valid/mixer/aborted      - one-cycle completion report
//   err_bad_id                    - one-cycle pulse for an out-of-range index
//   fifo_count                    - queued command count
module mix_scheduler
    import mix_ctrl_pkg::*;
#(
    parameter int NUM_MIXERS   = DEF_NUM_MIXERS,
    parameter int FIFO_DEPTH   = 4,
    parameter int LOAD_CYCLES  = DEF_LOAD_CYCLES,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int DUR_W        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [6:0]                    cmd_mixer,
    input  logic [DUR_W-1:0]              cmd_dur,
    input  logic                          abort,
    output logic                          act_en,
    output logic [6:0]                    act_mixer,
    output logic [2:0]                    act_phase,
    output logic                          done_valid,
    output logic [6:0]                    done_mixer,
    output logic                          done_aborted,
    output logic                          err_bad_id,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CNT_W = max_int(DUR_W, $clog2(LOAD_CYCLES));
    localparam int QW    = MIXER_W + DUR_W;

    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

    phase_e             state;
    logic [CNT_W-1:0]   cnt;
    logic [DUR_W-1:0]   cur_dur;
    logic               aborted;

    logic               q_full;
    logic               q_empty;
    logic [QW-1:0]      q_head;
    logic [MIXER_W-1:0] head_mixer;
    logic [DUR_W-1:0]   head_dur;
    logic               accept;
    logic               id_ok;
    logic               push;
    logic               pop;
    logic               last_flush;
    logic [CNT_W-1:0]   mix_last;

    assign cmd_ready  = !q_full;
    assign accept     = cmd_valid && cmd_ready;
    assign id_ok      = 32'(cmd_mixer) < NUM_MIXERS;
    assign push       = accept && id_ok;
    assign last_flush = (state == PH_FLUSH) && (cnt == '0);
    // Dequeue on the same edge the FSM latches the head entry.
    assign pop        = ((state == PH_IDLE) || last_flush) && !q_empty;
    assign {head_mixer, head_dur} = q_head;
    // A zero duration still mixes for one cycle.
    assign mix_last   = (cur_dur == '0) ? '0 : CNT_W'(cur_dur - 1'b1);
    assign act_phase  = state;

    mix_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (QW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data ({cmd_mixer, cmd_dur}),
        .rd_en   (pop),
        .rd_data (q_head),
        .count   (fifo_count),
        .full    (q_full),
        .empty   (q_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= PH_IDLE;
            cnt          <= '0;
            cur_dur      <= '0;
            aborted      <= 1'b0;
            act_en       <= 1'b0;
            act_mixer    <= '0;
            done_valid   <= 1'b0;
            done_mixer   <= '0;
            done_aborted <= 1'b0;
            err_bad_id   <= 1'b0;
        end else begin
            done_valid   <= 1'b0;
            done_aborted <= 1'b0;
            err_bad_id   <= accept && !id_ok;
            case (state)
                PH_IDLE: begin
                    if (!q_empty) begin
                        state     <= PH_LOAD_A;
                        cnt       <= LOAD_LAST;
                        cur_dur   <= head_dur;
                        aborted   <= 1'b0;
                        act_en    <= 1'b1;
                        act_mixer <= head_mixer;
                    end
                end
                PH_LOAD_A, PH_LOAD_B, PH_MIX: begin
                    if (abort) begin
                        state   <= PH_FLUSH;
                        cnt     <= FLUSH_LAST;
                        aborted <= 1'b1;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (state == PH_LOAD_A) begin
                        state <= PH_LOAD_B;
                        cnt   <= LOAD_LAST;
                    end else if (state == PH_LOAD_B) begin
                        state <= PH_MIX;
                        cnt   <= mix_last;
                    end else begin
                        state <= PH_FLUSH;
                        cnt   <= FLUSH_LAST;
                    end
                end
                PH_FLUSH: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        done_valid   <= 1'b1;
                        done_mixer   <= act_mixer;
                        done_aborted <= aborted;
                        // Chain straight into the next queued command.
                        if (!q_empty) begin
                            state     <= PH_LOAD_A;
                            cnt       <= LOAD_LAST;
                            cur_dur   <= head_dur;
                            aborted   <= 1'b0;
                            act_mixer <= head_mixer;
                        end else begin
                            state     <= PH_IDLE;
                            act_en    <= 1'b0;
                            act_mixer <= '0;
                        end
                    end
                end
                default: begin
                    state     <= PH_IDLE;
                    act_en    <= 1'b0;
                    act_mixer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_scheduler.sv
// Self-checking bench for mix_scheduler: directed scenarios plus randomized
// traffic, compared against a phase-plan reference model.
module tb_mix_scheduler;

    localparam int NUM_MIXERS   = 70;
    localparam int FIFO_DEPTH   = 4;
    localparam int LOAD_CYCLES  = 8;
    localparam int FLUSH_CYCLES = 4;
    localparam int DUR_W        = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [6:0]  cmd_mixer = '0;
    logic [15:0] cmd_dur = '0;
    logic        abort = 1'b0;
    logic        act_en;
    logic [6:0]  act_mixer;
    logic [2:0]  act_phase;
    logic        done_valid;
    logic [6:0]  done_mixer;
    logic        done_aborted;
    logic        err_bad_id;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    mix_scheduler #(
        .NUM_MIXERS   (NUM_MIXERS),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .LOAD_CYCLES  (LOAD_CYCLES),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .DUR_W        (DUR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_mixer    (cmd_mixer),
        .cmd_dur      (cmd_dur),
        .abort        (abort),
        .act_en       (act_en),
        .act_mixer    (act_mixer),
        .act_phase    (act_phase),
        .done_valid   (done_valid),
        .done_mixer   (done_mixer),
        .done_aborted (done_aborted),
        .err_bad_id   (err_bad_id),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    // Reference model: each running command is a list of per-cycle phases.
    typedef struct {
        int mixer;
        int dur;
    } cmd_t;

    cmd_t m_q[$];
    int   plan[$];
    int   m_phase = 0;
    int   m_mixer = 0;
    int   m_dm = 0;
    bit   m_dv = 0;
    bit   m_da = 0;
    bit   m_err = 0;
    bit   m_ab = 0;
    bit   m_acc, m_ok, m_fin;
    cmd_t m_c;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            plan.delete();
            m_phase = 0; m_mixer = 0; m_dm = 0;
            m_dv = 0; m_da = 0; m_err = 0; m_ab = 0;
        end else begin
            m_acc = cmd_valid && (m_q.size() < FIFO_DEPTH);
            m_ok  = int'(cmd_mixer) < NUM_MIXERS;
            m_fin = 0;
            m_dv  = 0;
            m_da  = 0;
            if (m_phase != 0) begin
                if (abort && m_phase != 4) begin
                    plan.delete();
                    for (int i = 0; i < FLUSH_CYCLES; i++) plan.push_back(4);
                    m_ab = 1;
                end else begin
                    void'(plan.pop_front());
                    if (plan.size() == 0) m_fin = 1;
                end
            end
            if (m_fin) begin
                m_dv = 1;
                m_dm = m_mixer;
                m_da = m_ab;
            end
            if ((m_phase == 0 || m_fin) && m_q.size() > 0) begin
                m_c = m_q.pop_front();
                for (int i = 0; i < LOAD_CYCLES; i++) plan.push_back(1);
                for (int i = 0; i < LOAD_CYCLES; i++) plan.push_back(2);
                for (int i = 0; i < ((m_c.dur == 0) ? 1 : m_c.dur); i++) plan.push_back(3);
                for (int i = 0; i < FLUSH_CYCLES; i++) plan.push_back(4);
                m_mixer = m_c.mixer;
                m_ab = 0;
            end else if (m_fin) begin
                m_mixer = 0;
            end
            m_phase = (plan.size() > 0) ? plan[0] : 0;
            if (m_acc && m_ok) m_q.push_back('{int'(cmd_mixer), int'(cmd_dur)});
            m_err = m_acc && !m_ok;
        end
    end

    function automatic logic [24:0] obs_vec();
        return {act_en, act_phase, act_mixer, done_valid, err_bad_id, cmd_ready,
                fifo_count, done_valid ? {done_aborted, done_mixer} : 8'h00};
    endfunction

    function automatic logic [24:0] exp_vec();
        return {m_phase != 0, 3'(m_phase), 7'(m_mixer), m_dv, m_err,
                m_q.size() < FIFO_DEPTH, 3'(m_q.size()),
                m_dv ? {m_da, 7'(m_dm)} : 8'h00};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({act_en, act_phase, act_mixer} !== 11'd0) begin
            errors++; $display("FAIL reset_act got %b exp 0", {act_en, act_phase, act_mixer});
        end
        checks++;
        if ({done_valid, done_mixer, done_aborted, err_bad_id} !== 10'd0) begin
            errors++; $display("FAIL reset_done got %b exp 0", {done_valid, done_mixer, done_aborted, err_bad_id});
        end
        checks++;
        if (cmd_ready !== 1'b1 || fifo_count !== 3'd0) begin
            errors++; $display("FAIL reset_queue got ready=%b count=%0d exp ready=1 count=0", cmd_ready, fifo_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int exp_ph;
        cmd_valid = 1'b1; cmd_mixer = 7'd12; cmd_dur = 16'd5;
        step();                       // accept edge is edge 0; now in cycle 1
        cmd_valid = 1'b0;
        for (int c = 1; c <= 28; c++) begin
            exp_ph = (c < 2) ? 0 : (c <= 9) ? 1 : (c <= 17) ? 2 : (c <= 22) ? 3 : (c <= 26) ? 4 : 0;
            checks++;
            if (int'(act_phase) !== exp_ph || act_mixer !== ((exp_ph != 0) ? 7'd12 : 7'd0)) begin
                errors++; $display("FAIL single_phase cyc %0d got ph=%0d mix=%0d exp ph=%0d", c, act_phase, act_mixer, exp_ph);
            end
            checks++;
            if (done_valid !== (c == 27) || (c == 27 && (done_mixer !== 7'd12 || done_aborted !== 1'b0))) begin
                errors++; $display("FAIL single_done cyc %0d got v=%b m=%0d exp v=%b m=12", c, done_valid, done_mixer, c == 27);
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL model_single cyc %0d got %h exp %h", c, obs_vec(), exp_vec());
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        int got[$];
        cmd_valid = 1'b1; cmd_mixer = 7'd3; cmd_dur = 16'd1;
        step();
        cmd_mixer = 7'd7;
        step();
        cmd_valid = 1'b0;
        for (int t = 0; t < 120 && got.size() < 2; t++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL model_b2b t=%0d got %h exp %h", t, obs_vec(), exp_vec());
            end
            if (done_valid === 1'b1) begin
                got.push_back(int'(done_mixer));
                if (got.size() == 1) begin
                    checks++;
                    if (act_phase !== 3'd1 || act_mixer !== 7'd7) begin
                        errors++; $display("FAIL b2b_chain got ph=%0d mix=%0d exp ph=1 mix=7", act_phase, act_mixer);
                    end
                end
            end
            step();
        end
        checks++;
        if (got.size() != 2 || got[0] != 3 || got[1] != 7) begin
            errors++; $display("FAIL b2b_order got %0d dones exp 2 in order 3,7", got.size());
        end
    endtask

    task automatic test_full_queue();
        int  got[$];
        int  idx = 0;
        bit  saw_full = 0;
        logic rdy;
        for (int t = 0; t < 600 && got.size() < 7; t++) begin
            if (idx < 7) begin
                cmd_valid = 1'b1; cmd_mixer = 7'(20 + idx); cmd_dur = 16'd2;
            end else begin
                cmd_valid = 1'b0;
            end
            rdy = cmd_ready;
            step();
            if (rdy === 1'b1 && cmd_valid) idx++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL model_full t=%0d got %h exp %h", t, obs_vec(), exp_vec());
            end
            if (cmd_ready === 1'b0 && fifo_count === 3'd4) saw_full = 1;
            if (done_valid === 1'b1) got.push_back(int'(done_mixer));
        end
        cmd_valid = 1'b0;
        checks++;
        if (saw_full !== 1'b1) begin
            errors++; $display("FAIL full_seen got 0 exp 1");
        end
        checks++;
        if (got.size() != 7) begin
            errors++; $display("FAIL full_count got %0d exp 7", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] != 20 + i) begin
                errors++; $display("FAIL full_order idx %0d got %0d exp %0d", i, got[i], 20 + i);
            end
        end
        step();
    endtask

    task automatic test_bad_id();
        bit seen = 0;
        cmd_valid = 1'b1; cmd_mixer = 7'd70; cmd_dur = 16'd3;
        step();
        cmd_valid = 1'b0;
        checks++;
        if (err_bad_id !== 1'b1 || fifo_count !== 3'd0 || act_phase !== 3'd0) begin
            errors++; $display("FAIL bad_id_pulse got err=%b cnt=%0d ph=%0d exp 1,0,0", err_bad_id, fifo_count, act_phase);
        end
        // Highest valid index with zero duration follows.
        cmd_valid = 1'b1; cmd_mixer = 7'd69; cmd_dur = 16'd0;
        step();
        cmd_valid = 1'b0;
        checks++;
        if (err_bad_id !== 1'b0 || fifo_count !== 3'd1 || act_phase !== 3'd0) begin
            errors++; $display("FAIL bad_id_next got err=%b cnt=%0d ph=%0d exp 0,1,0", err_bad_id, fifo_count, act_phase);
        end
        for (int t = 0; t < 60 && !seen; t++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL model_bad_id t=%0d got %h exp %h", t, obs_vec(), exp_vec());
            end
            if (done_valid === 1'b1) seen = 1;
        end
        checks++;
        if (seen !== 1'b1 || done_mixer !== 7'd69) begin
            errors++; $display("FAIL bad_id_done got seen=%b mix=%0d exp 1,69", seen, done_mixer);
        end
    endtask

    task automatic test_abort();
        int mix_seen = 0;
        bit reached = 0;
        bit seen = 0;
        cmd_valid = 1'b1; cmd_mixer = 7'd40; cmd_dur = 16'd100;
        step();
        cmd_mixer = 7'd41; cmd_dur = 16'd3;
        step();
        cmd_valid = 1'b0;
        for (int t = 0; t < 200; t++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL model_abort t=%0d got %h exp %h", t, obs_vec(), exp_vec());
            end
            if (act_phase === 3'd3) mix_seen++;
            if (mix_seen == 10) begin reached = 1; break; end
            step();
        end
        checks++;
        if (!reached) begin
            errors++; $display("FAIL abort_reach_mix got %0d mix cycles exp 10", mix_seen);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (act_phase !== 3'd4 || act_mixer !== 7'd40 || done_valid !== 1'b0) begin
                errors++; $display("FAIL abort_flush k=%0d got ph=%0d mix=%0d exp ph=4 mix=40", k, act_phase, act_mixer);
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL model_abort_flush k=%0d got %h exp %h", k, obs_vec(), exp_vec());
            end
            step();
        end
        checks++;
        if (done_valid !== 1'b1 || done_aborted !== 1'b1 || done_mixer !== 7'd40) begin
            errors++; $display("FAIL abort_done got v=%b a=%b m=%0d exp 1,1,40", done_valid, done_aborted, done_mixer);
        end
        checks++;
        if (act_phase !== 3'd1 || act_mixer !== 7'd41) begin
            errors++; $display("FAIL abort_next got ph=%0d mix=%0d exp 1,41", act_phase, act_mixer);
        end
        for (int t = 0; t < 60 && !seen; t++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL model_abort_next t=%0d got %h exp %h", t, obs_vec(), exp_vec());
            end
            if (done_valid === 1'b1) seen = 1;
        end
        checks++;
        if (seen !== 1'b1 || done_aborted !== 1'b0 || done_mixer !== 7'd41) begin
            errors++; $display("FAIL abort_second got seen=%b a=%b m=%0d exp 1,0,41", seen, done_aborted, done_mixer);
        end
    endtask

    task automatic test_reset_mid();
        bit reached = 0;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd_mixer = 7'(5 + i); cmd_dur = 16'd2;
            step();
        end
        cmd_valid = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (act_phase === 3'd2) begin reached = 1; break; end
            step();
        end
        checks++;
        if (!reached || fifo_count !== 3'd2) begin
            errors++; $display("FAIL rst_mid_setup got reached=%b cnt=%0d exp 1,2", reached, fifo_count);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (act_phase !== 3'd0 || act_en !== 1'b0 || fifo_count !== 3'd0 || cmd_ready !== 1'b1 || done_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_state got ph=%0d en=%b cnt=%0d rdy=%b dv=%b exp 0,0,0,1,0",
                               act_phase, act_en, fifo_count, cmd_ready, done_valid);
        end
        for (int t = 0; t < 40; t++) begin
            step();
            checks++;
            if (done_valid !== 1'b0 || act_en !== 1'b0) begin
                errors++; $display("FAIL rst_mid_quiet t=%0d got dv=%b en=%b exp 0,0", t, done_valid, act_en);
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 3000; t++) begin
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_mixer = 7'($urandom_range(0, 79));
            cmd_dur   = 16'($urandom_range(0, 6));
            abort     = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 499) == 0);
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL model_random t=%0d got %h exp %h", t, obs_vec(), exp_vec());
            end
        end
        cmd_valid = 1'b0;
        abort = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_full_queue();
        test_bad_id();
        test_abort();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
